crucial_token_sel: RTL

Parametrised crucial-token selector. It accepts a score-sorted token stream over a ready/valid handshake and buffers it. It then walks the list in order, reading each candidate's row from the binary map buffer, and emits a greedy-cover (or plain) top-K set of token indices. It sits between the score sorter and downstream token consumers. It generalises the fixed 16-token selector with configurable depth, top-K cap, score threshold, selection mode and input back-pressure.

---
 rtl/crucial_token_sel.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/crucial_token_sel.sv
// rtl/crucial_token_sel.sv - greedy-cover / plain top-K crucial token selector
module crucial_token_sel #(
    parameter int DIMEN   = 16,
    parameter int IDX_W   = 4,
    parameter int MAP_W   = 4,
    parameter int SCORE_W = 32,
    parameter int TOPK    = 16,
    parameter int MODE    = 1
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic               start,
    input  logic [SCORE_W-1:0] thr,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [SCORE_W-1:0] sort_res,
    input  logic [IDX_W:0]     sort_index,
    output logic               read_finish,
    output logic [MAP_W:0]     map_addr,
    output logic               map_cen,
    output logic               map_wen,
    output logic               map_ren,
    input  logic [DIMEN-1:0]   map_row,
    output logic [IDX_W:0]     token,
    output logic               valid,
    output logic               find_finish,
    output logic               busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SCAN,
        S_WAIT,
        S_DONE
    } state_t;

    localparam logic [IDX_W:0]   ONE_V   = (IDX_W+1)'(1);
    localparam logic [IDX_W:0]   DIM_V   = (IDX_W+1)'(DIMEN);
    localparam logic [IDX_W:0]   TOPK_V  = (IDX_W+1)'(TOPK);
    localparam logic [DIMEN-1:0] BIT0    = DIMEN'(1);

    state_t state, state_n;

    logic [SCORE_W-1:0] score_mem [DIMEN];
    logic [IDX_W:0]     idx_mem   [DIMEN];
    logic [IDX_W:0]     ld_cnt;
    logic [IDX_W:0]     k;
    logic [IDX_W:0]     cnt;
    logic [DIMEN-1:0]   covered;
    logic [DIMEN-1:0]   emitted;
    logic [SCORE_W-1:0] thr_q;
    logic [IDX_W:0]     token_q;
    logic               valid_q;
    logic               rf_q;

    logic [IDX_W-1:0]   k_sel;
    logic [SCORE_W-1:0] cur_score;
    logic [IDX_W:0]     cur_idx;
    logic [IDX_W:0]     cur_bit;
    logic [DIMEN-1:0]   cur_onehot;
    logic               idx_ok;
    logic               stop;
    logic               skip;

    // Candidate under examination and the stop/skip decisions for it
    always_comb begin
        k_sel      = k[IDX_W-1:0];
        cur_score  = score_mem[k_sel];
        cur_idx    = idx_mem[k_sel];
        cur_bit    = cur_idx - ONE_V;
        cur_onehot = BIT0 << cur_bit;
        idx_ok     = (cur_idx != '0) && (cur_idx <= DIM_V);
        // k==DIMEN is tested first so the stale slot read at that point never matters
        stop       = (k == DIM_V) || (cnt == TOPK_V) || (cur_score < thr_q) ||
                     ((MODE == 1) && (&covered));
        skip       = !idx_ok ||
                     ((MODE == 1) && |(covered & cur_onehot)) ||
                     ((MODE != 1) && |(emitted & cur_onehot));
    end

    // State register
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) state <= S_IDLE;
        else        state <= state_n;
    end

    // Next-state logic and combinational outputs
    always_comb begin
        state_n     = state;
        in_ready    = 1'b0;
        map_cen     = 1'b0;
        map_addr    = '0;
        find_finish = 1'b0;
        busy        = (state != S_IDLE);
        case (state)
            S_IDLE: if (start) state_n = S_LOAD;
            S_LOAD: begin
                in_ready = 1'b1;
                if (in_valid && (ld_cnt == DIM_V - ONE_V)) state_n = S_SCAN;
            end
            S_SCAN: begin
                if (stop) begin
                    state_n = S_DONE;
                end else if (!skip) begin
                    map_cen  = 1'b1;
                    map_addr = (MAP_W+1)'(cur_bit);
                    state_n  = S_WAIT;
                end
            end
            S_WAIT: state_n = S_SCAN;
            S_DONE: begin
                find_finish = 1'b1;
                state_n     = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    assign map_ren     = map_cen;
    assign map_wen     = 1'b1;
    assign token       = token_q;
    assign valid       = valid_q;
    assign read_finish = rf_q;

    // Datapath: list load, scan pointer, coverage bitmaps and emission registers
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            for (int i = 0; i < DIMEN; i++) begin
                score_mem[i] <= '0;
                idx_mem[i]   <= '0;
            end
            ld_cnt  <= '0;
            k       <= '0;
            cnt     <= '0;
            covered <= '0;
            emitted <= '0;
            thr_q   <= '0;
            token_q <= '0;
            valid_q <= 1'b0;
            rf_q    <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            rf_q    <= (state == S_LOAD) && (state_n == S_SCAN);
            case (state)
                S_IDLE: begin
                    for (int i = 0; i < DIMEN; i++) begin
                        score_mem[i] <= '0;
                        idx_mem[i]   <= '0;
                    end
                    ld_cnt  <= '0;
                    k       <= '0;
                    cnt     <= '0;
                    covered <= '0;
                    emitted <= '0;
                    if (start) thr_q <= thr;
                end
                S_LOAD: begin
                    if (in_valid) begin
                        score_mem[ld_cnt[IDX_W-1:0]] <= sort_res;
                        idx_mem[ld_cnt[IDX_W-1:0]]   <= sort_index;
                        ld_cnt                       <= ld_cnt + ONE_V;
                    end
                end
                S_SCAN: begin
                    if (!stop && skip) k <= k + ONE_V;
                end
                S_WAIT: begin
                    token_q <= cur_idx;
                    valid_q <= 1'b1;
                    covered <= covered | map_row | cur_onehot;
                    emitted <= emitted | cur_onehot;
                    cnt     <= cnt + ONE_V;
                    k       <= k + ONE_V;
                end
                default: ;
            endcase
        end
    end

endmodule
